multicycle_alu: RTL

Iterative 16-bit ALU for the CPU execute stage, directly upstream of the status register encoder. It accepts one operation per start pulse and computes it in one cycle (add/sub/logic), k cycles (shift by k) or 16 cycles (shift-add multiply). It then presents `add_out` and `c_out`, which feed the status encoder's N/Z/P/C flag generation, along with a one-cycle `done` strobe.

---
 rtl/alu_pkg.sv | 26 ++
 rtl/alu_comb.sv | 38 +++
 rtl/multicycle_alu.sv | 137 +++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared constants and types for the iterative execute-stage ALU.
package alu_pkg;

    localparam int WIDTH = 16;
    localparam int CNT_W = 5;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_XOR = 3'b100;
    localparam logic [2:0] ALU_SHL = 3'b101;
    localparam logic [2:0] ALU_SHR = 3'b110;
    localparam logic [2:0] ALU_MUL = 3'b111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } alu_state_t;

    function automatic logic is_shift(input logic [2:0] op);
        return (op == ALU_SHL) || (op == ALU_SHR);
    endfunction

endpackage

// File: rtl/alu_comb.sv
// Single-cycle arithmetic/logic slice: ADD, SUB (a + ~b + 1) and bitwise ops with carry.
module alu_comb #(
    parameter int W = 16
) (
    input  logic [2:0]   op_i,
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    output logic [W-1:0] y_o,
    output logic         c_o
);
    import alu_pkg::*;

    logic [W:0] sum;

    always_comb begin
        // NOTE: every output gets a default first, so no branch can infer a latch.
        sum = '0;
        y_o = '0;
        c_o = 1'b0;
        case (op_i)
            ALU_ADD: begin
                sum = {1'b0, a_i} + {1'b0, b_i};
                y_o = sum[W-1:0];
                c_o = sum[W];
            end
            ALU_SUB: begin
                sum = {1'b0, a_i} + {1'b0, ~b_i} + (W+1)'(1);
                y_o = sum[W-1:0];
                c_o = sum[W];
            end
            ALU_AND: y_o = a_i & b_i;
            ALU_OR:  y_o = a_i | b_i;
            ALU_XOR: y_o = a_i ^ b_i;
            default: y_o = '0;
        endcase
    end

endmodule

// File: rtl/multicycle_alu.sv
// Iterative 16-bit ALU: one-cycle ADD/SUB/logic, k-cycle shifts, 16-cycle shift-add multiply.
module multicycle_alu #(
    parameter int WIDTH = alu_pkg::WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] add_out,
    output logic             c_out
);
    import alu_pkg::*;

    alu_state_t         state_q, state_d;
    logic [2:0]         op_q, op_d;
    logic [2*WIDTH-1:0] mcand_q, mcand_d;   // multiplicand, or the shift operand in its low half
    logic [WIDTH-1:0]   mplr_q, mplr_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   res_q, res_d;
    logic               c_q, c_d;
    logic               shout;

    logic [WIDTH-1:0]   comb_y;
    logic               comb_c;

    alu_comb #(.W(WIDTH)) u_comb (
        .op_i (op),
        .a_i  (a),
        .b_i  (b),
        .y_o  (comb_y),
        .c_o  (comb_c)
    );

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        mcand_d = mcand_q;
        mplr_d  = mplr_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        res_d   = res_q;
        c_d     = c_q;
        shout   = 1'b0;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    op_d = op;
                    if (is_shift(op) && (b[3:0] == 4'd0)) begin
                        res_d   = a;
                        c_d     = 1'b0;
                        state_d = DONE;
                    end else if (is_shift(op)) begin
                        mcand_d = {{WIDTH{1'b0}}, a};
                        cnt_d   = {1'b0, b[3:0]};
                        state_d = EXEC;
                    end else if (op == ALU_MUL) begin
                        mcand_d = {{WIDTH{1'b0}}, a};
                        mplr_d  = b;
                        acc_d   = '0;
                        cnt_d   = CNT_W'(WIDTH);
                        state_d = EXEC;
                    end else begin
                        res_d   = comb_y;
                        c_d     = comb_c;
                        state_d = DONE;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            EXEC: begin
                cnt_d = cnt_q - CNT_W'(1);
                case (op_q)
                    ALU_SHL: begin
                        shout                = mcand_q[WIDTH-1];
                        mcand_d[WIDTH-1:0]   = {mcand_q[WIDTH-2:0], 1'b0};
                    end
                    ALU_SHR: begin
                        shout                = mcand_q[0];
                        mcand_d[WIDTH-1:0]   = {1'b0, mcand_q[WIDTH-1:1]};
                    end
                    default: begin
                        acc_d   = acc_q + (mplr_q[0] ? mcand_q : '0);
                        mcand_d = mcand_q << 1;
                        mplr_d  = mplr_q >> 1;
                    end
                endcase
                // Results are taken from the next-state values so they land on the edge entering DONE.
                if (cnt_q == CNT_W'(1)) begin
                    state_d = DONE;
                    if (op_q == ALU_MUL) begin
                        res_d = acc_d[WIDTH-1:0];
                        c_d   = |acc_d[2*WIDTH-1:WIDTH];
                    end else begin
                        res_d = mcand_d[WIDTH-1:0];
                        c_d   = shout;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
        if (!rst_n) begin
            state_q <= IDLE;
            op_q    <= ALU_ADD;
            mcand_q <= '0;
            mplr_q  <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            res_q   <= '0;
            c_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            mcand_q <= mcand_d;
            mplr_q  <= mplr_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            res_q   <= res_d;
            c_q     <= c_d;
        end
    end

    assign busy    = (state_q == EXEC);
    assign done    = (state_q == DONE);
    assign add_out = res_q;
    assign c_out   = c_q;

endmodule
